imem_fetch: RTL and testbench

Instruction fetch initiator that drives the byte address into the instruction memory and consumes the 32-bit word it returns. It keeps the program counter, buffers fetched instructions in a small queue, and hands them to decode over a valid/ready handshake. It also accepts PC redirects from branch resolution and stops cleanly on out-of-range fetches. It sits between the instruction memory and the decode stage of the processor.

---
 rtl/imem_fetch_pkg.sv | 28 ++
 rtl/imem_fetch_if.sv | 58 +++++
 rtl/imem_fetch_queue.sv | 78 +++++++
 rtl/imem_fetch.sv | 143 ++++++++++++++
 tb/tb_imem_fetch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_pkg
// Shared types and constants for the instruction fetch block:
//   fetch_state_t : fetch controller state (IDLE, RUN, HALT)
//   fetch_entry_t : one queued fetch result {instr, pc}
//   WORD_BYTES    : bytes per instruction word
//   word_align()  : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int unsigned WORD_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_if
// Groups the instruction-memory port, the redirect request and the decode
// handshake of the fetch block.
//   master : the fetch block (drives imem_a, out_*, halted, align_err)
//   slave  : the environment (memory, branch resolution, decode)
// Signals:
//   imem_a      byte address to instruction memory (word aligned)
//   imem_rd     instruction word for imem_a, same cycle
//   redirect    load redirect_pc and flush the queue
//   redirect_pc redirect target byte address
//   out_valid   out_instr/out_pc hold a valid entry
//   out_ready   decode accepts the head entry
//   out_instr   instruction at the queue head
//   out_pc      byte address of out_instr
//   halted      fetch stopped on an out-of-range pc
//   align_err   sticky: a redirect target was not word aligned
// -----------------------------------------------------------------------------
interface imem_fetch_if;

    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        align_err;

    modport master (
        output imem_a,
        input  imem_rd,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted,
        output align_err
    );

    modport slave (
        input  imem_a,
        output imem_rd,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted,
        input  align_err
    );

endinterface

// File: rtl/imem_fetch_queue.sv
// -----------------------------------------------------------------------------
// imem_fetch_queue
// Small FIFO of fetch_entry_t between the fetch controller and decode.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data (ignored when full unless popping too)
//   push_data   entry to enqueue
//   pop         remove the head entry (ignored when empty)
//   flush       discard all entries; wins over push
//   head        entry at the head of the queue
//   full, empty occupancy flags
//   count       number of stored entries
// -----------------------------------------------------------------------------
module imem_fetch_queue
    import imem_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = entries[rd_ptr];

    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array is reset along with the pointers so the head
    // (and therefore out_instr/out_pc) reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values of the pointers, regardless of statement order.
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// -----------------------------------------------------------------------------
// imem_fetch
// Instruction fetch initiator: holds the pc, presents it to instruction
// memory, queues {instr, pc} results and hands them to decode over a
// valid/ready handshake. Accepts redirects (flush + new pc) and halts when
// the pc leaves the memory range.
// Parameters:
//   RESET_PC  first byte address fetched after reset
//   MEM_WORDS instruction memory size in 32-bit words
//   QDEPTH    instruction queue depth (power of two, >= 2)
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         imem_fetch_if.master (memory, redirect, decode, status)
//   perf_fetches, perf_stalls  (only with IMEM_FETCH_PERF_EN defined)
//               committed fetches / RUN cycles blocked by a full queue
// Configuration macro: IMEM_FETCH_PERF_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_fetch_if.master bus
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_stalls
`endif
);

    localparam int unsigned CW      = $clog2(QDEPTH) + 1;
    localparam logic [31:0] LAST_PC = 32'(MEM_WORDS * WORD_BYTES - WORD_BYTES);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          align_err_q;

    logic          flush_req;
    logic          in_range;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_head;
    fetch_entry_t  q_wdata;

    // Redirects are ignored in IDLE; elsewhere they override everything.
    assign flush_req = bus.redirect && (state_q != IDLE);
    assign in_range  = (pc_q <= LAST_PC);
    assign q_pop     = !q_empty && bus.out_ready;
    assign q_wdata   = '{instr: bus.imem_rd, pc: pc_q};

    // NOTE: every always_comb output gets a default first, so no path through
    // the case/if tree can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        q_push  = 1'b0;
        if (flush_req) begin
            state_d = RUN;
            pc_d    = word_align(bus.redirect_pc);
        end else begin
            unique case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (!in_range) begin
                        state_d = HALT;
                    end else if (!q_full || bus.out_ready) begin
                        q_push = 1'b1;
                        pc_d   = pc_q + 32'(WORD_BYTES);
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            align_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (flush_req && (bus.redirect_pc[1:0] != 2'b00)) begin
                align_err_q <= 1'b1;
            end
        end
    end

    imem_fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .flush     (flush_req),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // imem_a is a pure register output: no input reaches it combinationally.
    assign bus.imem_a    = pc_q;
    assign bus.out_valid = !q_empty;
    assign bus.out_instr = q_head.instr;
    assign bus.out_pc    = q_head.pc;
    assign bus.halted    = (state_q == HALT);
    assign bus.align_err = align_err_q;

    // Occupancy can never exceed the configured depth.
    count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        q_count <= CW'(QDEPTH));

`ifdef IMEM_FETCH_PERF_EN
    logic stall;

    // A stall is a RUN cycle that wanted to fetch but found the queue full.
    assign stall = (state_q == RUN) && !flush_req && in_range
                   && q_full && !bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches <= '0;
            perf_stalls  <= '0;
        end else begin
            perf_fetches <= perf_fetches + 32'(q_push);
            perf_stalls  <= perf_stalls + 32'(stall);
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch
// Directed bench for imem_fetch. Instruction memory word k holds
// 32'hA000_0000 + k; addresses past the memory return 32'hDEAD_BEEF.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// "cycle n" below means the interval after the n-th rising edge following
// reset release (cycle 0 is the IDLE cycle).
// -----------------------------------------------------------------------------
module tb_imem_fetch;

    logic clk;
    logic rst_n;

    imem_fetch_if bus ();

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_stalls;
`endif

    imem_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (64),
        .QDEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .perf_fetches (perf_fetches),
        .perf_stalls  (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [64];

    initial begin
        for (int k = 0; k < 64; k++) imem[k] = 32'hA000_0000 + 32'(k);
    end

    always_comb begin
        if (bus.imem_a[31:2] < 30'd64) bus.imem_rd = imem[bus.imem_a[7:2]];
        else                           bus.imem_rd = 32'hDEAD_BEEF;
    end

    int n_cmp;
    int n_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (IDLE) with the given out_ready level.
    task automatic apply_reset(input logic ready);
        rst_n           = 1'b0;
        bus.out_ready   = ready;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        tick();
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.imem_a !== 32'h0) begin n_bad++; $display("FAIL reset_imem_a: got %h want 00000000", bus.imem_a); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr: got %h want 00000000", bus.out_instr); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_out_pc: got %h want 00000000", bus.out_pc); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        n_cmp++; if (bus.align_err !== 1'b0) begin n_bad++; $display("FAIL reset_align_err: got %b want 0", bus.align_err); end
`ifdef IMEM_FETCH_PERF_EN
        n_cmp++; if (perf_fetches !== 32'h0 || perf_stalls !== 32'h0) begin n_bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetches, perf_stalls); end
`endif
    endtask

    // Streaming with out_ready high: one instruction per cycle from pc 0.
    task automatic test_stream();
        apply_reset(1'b1);
        tick(); // cycle 1: first fetch presented, nothing queued yet
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_latency_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.imem_a !== 32'h0) begin n_bad++; $display("FAIL stream_first_addr: got %h want 00000000", bus.imem_a); end
        for (int k = 0; k < 6; k++) begin
            tick(); // cycle 2+k shows word k
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.out_valid); end
            n_cmp++; if (bus.out_pc !== 32'(4 * k)) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.out_pc, 32'(4 * k)); end
            n_cmp++; if (bus.out_instr !== 32'hA000_0000 + 32'(k)) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, bus.out_instr, 32'hA000_0000 + 32'(k)); end
        end
    endtask

    // out_ready low through cycles 1..5: fetches at 0 and 4 commit, the queue
    // is full from cycle 3 and cycles 3,4,5 are stalls with imem_a parked at 8.
    task automatic test_stall();
        apply_reset(1'b0);
        tick();
        tick(); // cycle 2
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL stall_head: got %h want 00000000", bus.out_pc); end
        for (int c = 3; c <= 6; c++) begin
            tick();
            n_cmp++; if (bus.imem_a !== 32'h8) begin n_bad++; $display("FAIL stall_addr_c%0d: got %h want 00000008", c, bus.imem_a); end
        end
        // cycle 6
`ifdef IMEM_FETCH_PERF_EN
        n_cmp++; if (perf_stalls !== 32'd3) begin n_bad++; $display("FAIL stall_perf_stalls: got %0d want 3", perf_stalls); end
        n_cmp++; if (perf_fetches !== 32'd2) begin n_bad++; $display("FAIL stall_perf_fetches: got %0d want 2", perf_fetches); end
`endif
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k)) begin n_bad++; $display("FAIL stall_drain[%0d]: got v=%b pc=%h want v=1 pc=%h", k, bus.out_valid, bus.out_pc, 32'(4 * k)); end
            n_cmp++; if (bus.out_instr !== 32'hA000_0000 + 32'(k)) begin n_bad++; $display("FAIL stall_drain_instr[%0d]: got %h want %h", k, bus.out_instr, 32'hA000_0000 + 32'(k)); end
            tick();
        end
    endtask

    // Redirect with a full queue, then misaligned and aligned redirects.
    task automatic test_redirect();
        apply_reset(1'b0);
        tick();
        tick();
        tick(); // cycle 3: queue holds 0 and 4
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL redir_pre: got v=%b pc=%h want v=1 pc=00000000", bus.out_valid, bus.out_pc); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        tick(); // cycle 4
        bus.redirect = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.imem_a !== 32'h40) begin n_bad++; $display("FAIL redir_addr: got %h want 00000040", bus.imem_a); end
        tick(); // cycle 5
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40) begin n_bad++; $display("FAIL redir_target_pc: got v=%b pc=%h want v=1 pc=00000040", bus.out_valid, bus.out_pc); end
        n_cmp++; if (bus.out_instr !== 32'hA000_0010) begin n_bad++; $display("FAIL redir_target_instr: got %h want a0000010", bus.out_instr); end
        n_cmp++; if (bus.align_err !== 1'b0) begin n_bad++; $display("FAIL redir_align_clean: got %b want 0", bus.align_err); end

        // Misaligned target, with a dequeue in the same cycle.
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h43;
        tick(); // cycle 6
        bus.redirect = 1'b0;
        n_cmp++; if (bus.align_err !== 1'b1) begin n_bad++; $display("FAIL misalign_flag: got %b want 1", bus.align_err); end
        n_cmp++; if (bus.imem_a !== 32'h40) begin n_bad++; $display("FAIL misalign_addr: got %h want 00000040", bus.imem_a); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL misalign_flush: got %b want 0", bus.out_valid); end
        tick(); // cycle 7
        n_cmp++; if (bus.out_pc !== 32'h40) begin n_bad++; $display("FAIL misalign_target: got %h want 00000040", bus.out_pc); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h10;
        tick(); // cycle 8
        bus.redirect = 1'b0;
        n_cmp++; if (bus.align_err !== 1'b1) begin n_bad++; $display("FAIL misalign_sticky: got %b want 1", bus.align_err); end
        n_cmp++; if (bus.imem_a !== 32'h10) begin n_bad++; $display("FAIL redir2_addr: got %h want 00000010", bus.imem_a); end
        tick(); // cycle 9
        n_cmp++; if (bus.out_pc !== 32'h10 || bus.out_instr !== 32'hA000_0004) begin n_bad++; $display("FAIL redir2_target: got pc=%h instr=%h want pc=00000010 instr=a0000004", bus.out_pc, bus.out_instr); end
    endtask

    // Run off the end of memory, drain while halted, redirect back to 0.
    task automatic test_halt();
        apply_reset(1'b1);
        tick(); // cycle 1
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hF0;
        tick(); // cycle 2
        bus.redirect = 1'b0;
        n_cmp++; if (bus.imem_a !== 32'hF0) begin n_bad++; $display("FAIL halt_redir_addr: got %h want 000000f0", bus.imem_a); end
        tick(); // cycle 3
        n_cmp++; if (bus.out_pc !== 32'hF0) begin n_bad++; $display("FAIL halt_seq_f0: got %h want 000000f0", bus.out_pc); end
        tick(); // cycle 4
        n_cmp++; if (bus.out_pc !== 32'hF4) begin n_bad++; $display("FAIL halt_seq_f4: got %h want 000000f4", bus.out_pc); end
        tick(); // cycle 5: head f8, fetching fc
        n_cmp++; if (bus.out_pc !== 32'hF8 || bus.imem_a !== 32'hFC) begin n_bad++; $display("FAIL halt_seq_f8: got pc=%h a=%h want pc=000000f8 a=000000fc", bus.out_pc, bus.imem_a); end
        bus.out_ready = 1'b0;
        tick(); // cycle 6: pc now 0x100, not yet halted
        n_cmp++; if (bus.imem_a !== 32'h100 || bus.halted !== 1'b0) begin n_bad++; $display("FAIL halt_edge: got a=%h h=%b want a=00000100 h=0", bus.imem_a, bus.halted); end
        tick(); // cycle 7
        n_cmp++; if (bus.halted !== 1'b1) begin n_bad++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hF8) begin n_bad++; $display("FAIL halt_keep_f8: got v=%b pc=%h want v=1 pc=000000f8", bus.out_valid, bus.out_pc); end
        bus.out_ready = 1'b1;
        tick(); // cycle 8
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFC || bus.out_instr !== 32'hA000_003F) begin n_bad++; $display("FAIL halt_drain_fc: got v=%b pc=%h instr=%h want v=1 pc=000000fc instr=a000003f", bus.out_valid, bus.out_pc, bus.out_instr); end
        tick(); // cycle 9
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1 || bus.imem_a !== 32'h100) begin n_bad++; $display("FAIL halt_empty: got v=%b h=%b a=%h want v=0 h=1 a=00000100", bus.out_valid, bus.halted, bus.imem_a); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        tick(); // cycle 10
        bus.redirect = 1'b0;
        n_cmp++; if (bus.halted !== 1'b0 || bus.imem_a !== 32'h0) begin n_bad++; $display("FAIL halt_resume: got h=%b a=%h want h=0 a=00000000", bus.halted, bus.imem_a); end
        tick(); // cycle 11
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'hA000_0000) begin n_bad++; $display("FAIL halt_resume_data: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=a0000000", bus.out_valid, bus.out_pc, bus.out_instr); end
    endtask

    // Reset asserted between edges with a full queue acts at once.
    task automatic test_async_reset();
        apply_reset(1'b0);
        tick();
        tick();
        tick();
        tick(); // cycle 4: queue full, imem_a parked at 8
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.imem_a !== 32'h8) begin n_bad++; $display("FAIL areset_pre: got v=%b a=%h want v=1 a=00000008", bus.out_valid, bus.imem_a); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.imem_a !== 32'h0) begin n_bad++; $display("FAIL areset_addr: got %h want 00000000", bus.imem_a); end
        n_cmp++; if (bus.halted !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL areset_state: got h=%b pc=%h instr=%h want h=0 pc=00000000 instr=00000000", bus.halted, bus.out_pc, bus.out_instr); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
